store_writer: RTL and testbench
===============================

# store_writer

Store-path write engine for the multi-cycle CPU: the outbound counterpart to the instruction/data capture registers that read memory. It accepts store requests (sb/sh/sw) from the control unit and buffers them in a small FIFO. For each request it performs byte-lane alignment and drives the data-memory write port, holding each write until memory acknowledges it. This lets the CPU continue while memory completes writes.

## Interface
Parameters:
- DEPTH, 2: store buffer entries; power of two, ≥2.
- AW, 32: address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request present.
- st_ready  out  1  buffer can accept a request.
- st_addr  in  AW  byte address.
- st_data  in  32  store data, right-justified.
- st_size  in  2  00 byte, 01 half, 10 word; 11 is reserved and treated as misaligned.
- mem_we  out  1  memory write strobe, registered.
- mem_addr  out  AW  word address: {addr[AW-1:2],2'b00}.
- mem_wdata  out  32  lane-aligned data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  memory accepted the current write.
- busy  out  1  FIFO non-empty or write in flight.
- err_misalign  out  1  sticky misaligned-store flag.

## Operation
- A request is accepted on a rising edge when st_valid && st_ready.
- st_ready = !full. It is combinational from the FIFO count.
- Alignment is computed at enqueue. The FIFO stores {word addr, wdata, be}.
  - byte: wdata = {4{data[7:0]}}; be = 4'b0001 << addr[1:0].
  - half: wdata = {2{data[15:0]}}; be = addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata = data; be = 4'b1111.
- Misaligned cases: half with addr[0]=1; word with addr[1:0]≠0; size 11.
  - The request is still handshaken (st_ready unaffected), but it is discarded, not enqueued.
  - err_misalign is set. It clears only on reset.
- FSM states: IDLE and WRITE.
  - IDLE: if the FIFO is non-empty, load the head into the mem_* registers, set mem_we=1, and go to WRITE.
  - WRITE: hold mem_addr/mem_wdata/mem_be/mem_we stable until mem_ack=1 is sampled. On ack, pop the head. If another entry remains, load it and stay in WRITE with mem_we=1. Otherwise set mem_we=0 and go to IDLE.
- mem_ack in IDLE is ignored.
- Simultaneous push and pop in one cycle are both performed; the count is unchanged.
- A push to a full FIFO is impossible because st_ready=0.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- busy = (count≠0) || mem_we.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, err_misalign=0, FSM=IDLE, FIFO empty, st_ready=1, busy=0.
- Reset is asynchronous. Asserting rst_n mid-write drops mem_we immediately and discards all buffered entries.
- Latency: an accept at edge N produces mem_we=1 after edge N+1 when the engine is IDLE.
- Throughput: one write per cycle when mem_ack is held high and the FIFO stays non-empty.
- After a pop on ack, the new entry is presented in the next cycle.
- st_ready rises in the cycle after the pop that frees a slot. No combinational path exists from mem_ack to st_ready.

## Configuration
- STORE_WRITER_MISALIGN_CHECK_EN
  - Defined: misaligned requests are discarded and set err_misalign, as above.
  - Undefined: there is no check. Low address bits are forced aligned per size (half uses addr[0]=0, word uses addr[1:0]=0), size 11 is treated as word, all requests are enqueued, and err_misalign is tied to 0.

## Structure
- Package store_writer_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum {ST_IDLE, ST_WRITE};
  - the FIFO entry struct {addr, wdata, be}.
- Sub-module store_fifo: a parameterized synchronous FIFO (DEPTH, entry width) with push/pop/full/empty/count, instantiated once.
- Alignment logic and FSM live in store_writer.

## Test plan
- Word store: addr 0x100, data 0xDEADBEEF, size 10, mem_ack one cycle after mem_we. Expect mem_addr 0x100, wdata 0xDEADBEEF, be 1111, and mem_we for exactly 2 cycles.
- Byte store: addr 0x203, data 0x000000A5. Expect mem_addr 0x200, wdata 0xA5A5A5A5, be 1000.
- Half store: addr 0x302, data 0x1234. Expect wdata 0x12341234, be 1100.
- Back-pressure: hold mem_ack=0 and push 3 words.
  - st_ready drops after the 2nd accept.
  - Release mem_ack high: expect 3 writes in order on consecutive acks.
  - busy falls 1 cycle after the last ack.
- Misaligned: word at 0x101 with the macro defined. Expect no mem_we and err_misalign=1 sticky. Without the macro, expect a write to 0x100 with be 1111.
- Reset during WRITE with 2 entries queued. Expect mem_we=0 at once and st_ready=1, and no writes after rst_n deasserts.

Source files
------------

// File: rtl/store_writer_pkg.sv
// Shared types for the store-path write engine: size encodings, FSM states,
// store-buffer entry layout and the byte-lane alignment helper.
package store_writer_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Address field width of a buffered entry; the top's AW must not exceed it.
  localparam int ST_AW = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  typedef struct packed {
    logic [ST_AW-1:0] addr;
    logic [31:0]      wdata;
    logic [3:0]       be;
  } st_entry_t;

  // Replicates right-justified store data across lanes and builds the byte
  // enables; off is the low two address bits, already aligned for the size.
  function automatic logic [35:0] align_lanes(input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic [31:0] data);
    logic [31:0] wdata;
    logic [3:0]  be;
    wdata = data;
    be    = 4'b1111;
    case (size)
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << off;
      end
      SZ_HALF: begin
        wdata = {2{data[15:0]}};
        be    = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = data;
        be    = 4'b1111;
      end
    endcase
    return {wdata, be};
  endfunction

endpackage

// File: rtl/store_writer_fifo.sv
// Small synchronous store buffer with head and head+1 read ports so the write
// engine can present the following entry in the same edge it pops the head.
module store_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [W-1:0]             next_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign rd_nxt  = rd_ptr_q + PW'(1);
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_nxt];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/store_writer.sv
// Store-path write engine: aligns sb/sh/sw requests, buffers them and drives
// the data-memory write port until acked. Option: STORE_WRITER_MISALIGN_CHECK_EN.
module store_writer
  import store_writer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [1:0]    st_size,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  output logic          busy,
  output logic          err_misalign
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(st_entry_t);

  st_entry_t     in_ent;
  st_entry_t     head_ent;
  st_entry_t     next_ent;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  state_e        state_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_be_q;

  // Handshake: a request transfers on a rising edge with st_valid && st_ready;
  // st_ready depends only on the registered FIFO count, never on mem_ack.
  assign st_ready = !fifo_full;

  always_comb begin
    in_ent      = '0;
    in_ent.addr = ST_AW'({st_addr[AW-1:2], 2'b00});
    {in_ent.wdata, in_ent.be} = align_lanes(st_addr[1:0], st_size, st_data);
  end

`ifdef STORE_WRITER_MISALIGN_CHECK_EN
  logic misalign;
  logic err_q;

  always_comb begin
    misalign = 1'b0;
    case (st_size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = st_addr[0];
      SZ_WORD: misalign = |st_addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  // Misaligned requests still complete the handshake but are dropped.
  assign push = st_valid && st_ready && !misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (st_valid && st_ready && misalign) err_q <= 1'b1;
  end

  assign err_misalign = err_q;
`else
  assign push         = st_valid && st_ready;
  assign err_misalign = 1'b0;
`endif

  // The in-flight entry stays in the FIFO until its ack pops it.
  assign pop = (state_q == ST_WRITE) && mem_ack;

  store_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (in_ent),
    .pop_i   (pop),
    .head_o  (head_ent),
    .next_o  (next_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mem_addr_q  <= head_ent.addr[AW-1:0];
            mem_wdata_q <= head_ent.wdata;
            mem_be_q    <= head_ent.be;
            mem_we_q    <= 1'b1;
            state_q     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            // An entry pushed this same edge is not visible yet; IDLE picks it up.
            if (fifo_count > CW'(1)) begin
              mem_addr_q  <= next_ent.addr[AW-1:0];
              mem_wdata_q <= next_ent.wdata;
              mem_be_q    <= next_ent.be;
              mem_we_q    <= 1'b1;
            end else begin
              mem_we_q <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
        end
        default: begin
          mem_we_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = (fifo_count != '0) || mem_we_q;

endmodule

// File: tb/tb_store_writer.sv
// Self-checking bench for store_writer: directed store scenarios plus random
// traffic against a byte-lane reference model of the store buffer.
module tb_store_writer;

  localparam int DEPTH = 2;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [1:0]    st_size;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic          busy;
  logic          err_misalign;

  always #5 clk = ~clk;

  store_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_size      (st_size),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .busy         (busy),
    .err_misalign (err_misalign)
  );

  // Reference state: pending writes {addr, wdata, be} in order.
  logic [67:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          occ = 0;
  int          idle_cnt = 0;
  int          we_cycles = 0;
  int          n_writes = 0;
  bit          exp_err = 1'b0;
  bit          expect_we = 1'b0;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_be;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds the expected memory write from the store rules: n-byte access,
  // lane offset rounded down to n, each lane i carries data byte (i mod n).
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       output logic [67:0] e, output bit ok);
    int          n;
    int          off;
    logic [31:0] wd;
    logic [3:0]  be;
    n = (s == 2'd3) ? 4 : (1 << s);
`ifdef STORE_WRITER_MISALIGN_CHECK_EN
    ok = (s != 2'd3) && ((a % n) == 0);
`else
    ok = 1'b1;
`endif
    off = (int'(a % 4) / n) * n;
    be  = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % n) +: 8];
    e = {a - (a % 4), wd, be};
  endtask

  // One cycle: check observables at the falling edge, then drive this cycle's
  // inputs and advance the reference model for the coming rising edge.
  task automatic tick(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input bit ack, output bit acc);
    logic [67:0] e;
    bit          ok;
    @(negedge clk);
    chk("st_ready", st_ready, occ < DEPTH);
    chk("busy", busy, occ != 0);
    chk("err_misalign", err_misalign, exp_err);
    if (expect_we) chk("we_expected", mem_we, 1'b1);
    if (occ == 0) chk("we_spurious", mem_we, 1'b0);
    if (occ != 0 && !mem_we) idle_cnt++;
    else idle_cnt = 0;
    if (occ != 0) begin
      chk("we_latency", idle_cnt > 1, 1'b0);
      if (idle_cnt > 1) idle_cnt = 0;
    end
    if (mem_we) we_cycles++;
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    mem_ack  = ack;
    expect_we = 1'b0;
    if (mem_we && ack) begin
      chk("write_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write", {mem_addr, mem_wdata, mem_be}, e);
        occ--;
      end
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
      last_be    = mem_be;
      n_writes++;
      expect_we = (occ > 0);
    end else if (mem_we) begin
      expect_we = 1'b1;
    end
    acc = v && st_ready;
    if (acc) begin
      model(a, d, s, e, ok);
      if (ok) begin
        exp_q.push_back(e);
        occ++;
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic idle_tick(input bit ack);
    bit acc;
    tick(1'b0, 32'h0, 32'h0, 2'd0, ack, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && occ != 0; i++) idle_tick(1'b1);
    idle_tick(1'b0);
    chk("drain", occ, 0);
  endtask

  // Accept one store, then ack its write one cycle after mem_we rises.
  task automatic single_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bit acc;
    tick(1'b1, a, d, s, 1'b0, acc);
    chk("single_accept", acc, 1'b1);
    we_cycles = 0;
    idle_tick(1'b0);
    idle_tick(1'b0);
    idle_tick(1'b1);
    idle_tick(1'b0);
    idle_tick(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          acc;
    int          w0;
    logic [31:0] ra;
    logic [1:0]  rs;

    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_size  = '0;
    mem_ack  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_err", err_misalign, 1'b0);
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Word store
    single_store(32'h100, 32'hDEADBEEF, 2'b10);
    chk("word_addr", last_addr, 32'h100);
    chk("word_wdata", last_wdata, 32'hDEADBEEF);
    chk("word_be", last_be, 4'b1111);
    chk("word_we_cycles", we_cycles, 2);

    // Byte store
    single_store(32'h203, 32'h000000A5, 2'b00);
    chk("byte_addr", last_addr, 32'h200);
    chk("byte_wdata", last_wdata, 32'hA5A5A5A5);
    chk("byte_be", last_be, 4'b1000);

    // Half store
    single_store(32'h302, 32'h00001234, 2'b01);
    chk("half_addr", last_addr, 32'h300);
    chk("half_wdata", last_wdata, 32'h12341234);
    chk("half_be", last_be, 4'b1100);

    // Back-pressure: three words with ack held low, then released.
    w0 = n_writes;
    tick(1'b1, 32'h400, 32'h11111111, 2'b10, 1'b0, acc);
    chk("bp_acc1", acc, 1'b1);
    tick(1'b1, 32'h404, 32'h22222222, 2'b10, 1'b0, acc);
    chk("bp_acc2", acc, 1'b1);
    tick(1'b1, 32'h408, 32'h33333333, 2'b10, 1'b0, acc);
    chk("bp_ready_low", acc, 1'b0);
    tick(1'b1, 32'h408, 32'h33333333, 2'b10, 1'b0, acc);
    chk("bp_still_low", acc, 1'b0);
    for (int i = 0; i < 10 && !acc; i++)
      tick(1'b1, 32'h408, 32'h33333333, 2'b10, 1'b1, acc);
    chk("bp_acc3", acc, 1'b1);
    drain();
    chk("bp_writes", n_writes - w0, 3);
    chk("bp_last_addr", last_addr, 32'h408);
    chk("bp_busy_low", busy, 1'b0);

    // Misaligned word
    w0 = n_writes;
    tick(1'b1, 32'h101, 32'hCAFEF00D, 2'b10, 1'b0, acc);
    chk("mis_accept", acc, 1'b1);
    idle_tick(1'b0);
    idle_tick(1'b1);
    idle_tick(1'b1);
    drain();
`ifdef STORE_WRITER_MISALIGN_CHECK_EN
    chk("mis_err", err_misalign, 1'b1);
    chk("mis_no_write", n_writes - w0, 0);
    single_store(32'h500, 32'h0BADCAFE, 2'b10);
    chk("mis_err_sticky", err_misalign, 1'b1);
`else
    chk("mis_err", err_misalign, 1'b0);
    chk("mis_write", n_writes - w0, 1);
    chk("mis_addr", last_addr, 32'h100);
    chk("mis_be", last_be, 4'b1111);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rs = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      ra = {20'h0, 10'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0) ra[1:0] = 2'($urandom);
      else if (rs == 2'b00) ra[1:0] = 2'($urandom);
      else if (rs == 2'b01) ra[1] = 1'($urandom);
      tick(1'($urandom_range(0, 1)), ra, $urandom, rs, $urandom_range(0, 2) != 0, acc);
    end
    drain();

    // Reset while writing with two entries queued
    w0 = n_writes;
    tick(1'b1, 32'h600, 32'hA0A0A0A0, 2'b10, 1'b0, acc);
    tick(1'b1, 32'h604, 32'hB0B0B0B0, 2'b10, 1'b0, acc);
    idle_tick(1'b0);
    chk("rstw_queued", occ, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_mem_we", mem_we, 1'b0);
    chk("rstw_st_ready", st_ready, 1'b1);
    chk("rstw_busy", busy, 1'b0);
    exp_q.delete();
    occ       = 0;
    exp_err   = 1'b0;
    expect_we = 1'b0;
    idle_cnt  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) idle_tick(1'b1);
    chk("rstw_no_writes", n_writes - w0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
